layer_sequencer: RTL and testbench

- Sequences one fully-connected layer of the neural-network datapath: N_NEURONS neurons, each computed as an N_INPUTS-term multiply-accumulate followed by activation and a write-back.
- Drives the address generator (reset/read), the ALU (reset/accumulate enable), the activation stage and the output-register write strobe.
- Talks to the top level through a start/done handshake, with an abort (`forget`) input.

---
 rtl/layer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Control sequencer for one fully-connected layer: for each neuron it clears the
// ALU, streams N_INPUTS multiply-accumulates, waits out the ALU latency, runs the
// activation stage and writes the result. Start/done handshake with abort.
module layer_sequencer #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 3,
  parameter int ALU_LAT   = 1,
  parameter int IDX_W     = 8,
  parameter int WADDR_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               forget,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               ag_rst,
  output logic               ag_read,
  output logic               alu_rst,
  output logic               alu_acc_en,
  output logic               act_en,
  output logic               out_wr,
  output logic [IDX_W-1:0]   in_idx,
  output logic [IDX_W-1:0]   out_idx,
  output logic [WADDR_W-1:0] weight_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_ACT,
    S_WRITE,
    S_DONE,
    S_ABORT
  } state_t;

  // Drain counter only needs to count 0..ALU_LAT-1; keep at least one bit.
  localparam int DRAIN_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [IDX_W-1:0]   IN_LAST    = IDX_W'(N_INPUTS - 1);
  localparam logic [IDX_W-1:0]   OUT_LAST   = IDX_W'(N_NEURONS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((ALU_LAT > 1) ? ALU_LAT - 1 : 0);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     in_idx_nxt, out_idx_nxt;
  logic [WADDR_W-1:0]   waddr_nxt;
  logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_nxt;

  // State and counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      in_idx      <= '0;
      out_idx     <= '0;
      drain_cnt   <= '0;
      weight_addr <= '0;
    end else begin
      state       <= state_nxt;
      in_idx      <= in_idx_nxt;
      out_idx     <= out_idx_nxt;
      drain_cnt   <= drain_cnt_nxt;
      weight_addr <= waddr_nxt;
    end
  end

  // Next-state and counter update. weight_addr tracks out_idx*N_INPUTS+in_idx
  // by incrementing whenever the flattened index advances by one, so no
  // multiplier is needed: both an in_idx step and the WRITE->CLEAR hop
  // (in_idx N_INPUTS-1 -> 0, out_idx +1) are a +1 on the flat address.
  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    in_idx_nxt    = in_idx;
    out_idx_nxt   = out_idx;
    drain_cnt_nxt = drain_cnt;
    waddr_nxt     = weight_addr;

    if (forget && state != S_IDLE && state != S_DONE && state != S_ABORT) begin
      // Abort wins over every other transition; counters are cleared on exit.
      state_nxt = S_ABORT;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt   = S_CLEAR;
            in_idx_nxt  = '0;
            out_idx_nxt = '0;
            waddr_nxt   = '0;
          end
        end
        S_CLEAR: state_nxt = S_ACCUM;
        S_ACCUM: begin
          if (in_idx == IN_LAST) begin
            drain_cnt_nxt = '0;
            state_nxt     = (ALU_LAT > 0) ? S_DRAIN : S_ACT;
          end else begin
            in_idx_nxt = in_idx + IDX_W'(1);
            waddr_nxt  = weight_addr + WADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt = S_ACT;
          end else begin
            drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
          end
        end
        S_ACT: state_nxt = S_WRITE;
        S_WRITE: begin
          if (out_idx == OUT_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt   = S_CLEAR;
            out_idx_nxt = out_idx + IDX_W'(1);
            in_idx_nxt  = '0;
            waddr_nxt   = weight_addr + WADDR_W'(1);
          end
        end
        S_DONE, S_ABORT: begin
          state_nxt     = S_IDLE;
          in_idx_nxt    = '0;
          out_idx_nxt   = '0;
          drain_cnt_nxt = '0;
          waddr_nxt     = '0;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore output decode of the registered state.
  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    aborted    = 1'b0;
    ag_rst     = 1'b0;
    ag_read    = 1'b0;
    alu_rst    = 1'b0;
    alu_acc_en = 1'b0;
    act_en     = 1'b0;
    out_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        busy    = 1'b0;
        ag_rst  = 1'b1;
        alu_rst = 1'b1;
      end
      S_CLEAR: alu_rst = 1'b1;
      S_ACCUM: begin
        ag_read    = 1'b1;
        alu_acc_en = 1'b1;
      end
      S_DRAIN: ;
      S_ACT:   act_en = 1'b1;
      S_WRITE: out_wr = 1'b1;
      S_DONE: begin
        done   = 1'b1;
        ag_rst = 1'b1;
      end
      S_ABORT: begin
        aborted = 1'b1;
        ag_rst  = 1'b1;
        alu_rst = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer. Two instances: the default
// configuration (4,3,1) and a minimal one (1,1,0). Expected per-cycle
// behaviour is derived from the cycle count since start using the per-neuron
// schedule CLEAR, N ACCUM, ALU_LAT DRAIN, ACT, WRITE, followed by DONE.
`timescale 1ns/1ps
module tb_layer_sequencer;

  localparam int A_NI = 4, A_NN = 3, A_LAT = 1;
  localparam int B_NI = 1, B_NN = 1, B_LAT = 0;

  typedef struct packed {
    logic       busy, done, aborted, ag_rst, ag_read, alu_rst, alu_acc_en, act_en, out_wr;
    logic [7:0] in_idx, out_idx, waddr;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, forget_a, start_b, forget_b;
  logic busy_a, done_a, aborted_a, ag_rst_a, ag_read_a, alu_rst_a, alu_acc_en_a, act_en_a, out_wr_a;
  logic busy_b, done_b, aborted_b, ag_rst_b, ag_read_b, alu_rst_b, alu_acc_en_b, act_en_b, out_wr_b;
  logic [7:0] in_idx_a, out_idx_a, waddr_a, in_idx_b, out_idx_b, waddr_b;

  int errors = 0;
  int checks = 0;

  layer_sequencer #(.N_INPUTS(A_NI), .N_NEURONS(A_NN), .ALU_LAT(A_LAT), .IDX_W(8), .WADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .forget(forget_a),
    .busy(busy_a), .done(done_a), .aborted(aborted_a), .ag_rst(ag_rst_a), .ag_read(ag_read_a),
    .alu_rst(alu_rst_a), .alu_acc_en(alu_acc_en_a), .act_en(act_en_a), .out_wr(out_wr_a),
    .in_idx(in_idx_a), .out_idx(out_idx_a), .weight_addr(waddr_a)
  );

  layer_sequencer #(.N_INPUTS(B_NI), .N_NEURONS(B_NN), .ALU_LAT(B_LAT), .IDX_W(8), .WADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .forget(forget_b),
    .busy(busy_b), .done(done_b), .aborted(aborted_b), .ag_rst(ag_rst_b), .ag_read(ag_read_b),
    .alu_rst(alu_rst_b), .alu_acc_en(alu_acc_en_b), .act_en(act_en_b), .out_wr(out_wr_b),
    .in_idx(in_idx_b), .out_idx(out_idx_b), .weight_addr(waddr_b)
  );

  function automatic obs_t get_obs(input bit sel);
    obs_t o;
    if (!sel) o = '{busy_a, done_a, aborted_a, ag_rst_a, ag_read_a, alu_rst_a, alu_acc_en_a,
                    act_en_a, out_wr_a, in_idx_a, out_idx_a, waddr_a};
    else      o = '{busy_b, done_b, aborted_b, ag_rst_b, ag_read_b, alu_rst_b, alu_acc_en_b,
                    act_en_b, out_wr_b, in_idx_b, out_idx_b, waddr_b};
    return o;
  endfunction

  // Reference model: k=0 is IDLE, k>=1 counts cycles after the edge that
  // sampled start. ctr_chk=0 where index values are not defined by the rules.
  function automatic obs_t model(input int ni, input int nn, input int lat,
                                 input int k, input int abort_at, output bit ctr_chk);
    obs_t e;
    int p, total, neuron, pos, in;
    e       = '0;
    ctr_chk = 1'b1;
    p       = ni + lat + 3;
    total   = nn * p;
    if (k == 0) begin
      e.ag_rst  = 1'b1;
      e.alu_rst = 1'b1;
    end else if (abort_at > 0 && k == abort_at + 1) begin
      e.busy = 1'b1; e.aborted = 1'b1; e.ag_rst = 1'b1; e.alu_rst = 1'b1;
      ctr_chk = 1'b0;
    end else if (k == total + 1) begin
      e.busy = 1'b1; e.done = 1'b1; e.ag_rst = 1'b1;
      ctr_chk = 1'b0;
    end else begin
      neuron = (k - 1) / p;
      pos    = (k - 1) % p;
      e.busy = 1'b1;
      if (pos == 0) begin
        e.alu_rst = 1'b1;
        in = 0;
      end else if (pos <= ni) begin
        e.ag_read = 1'b1; e.alu_acc_en = 1'b1;
        in = pos - 1;
      end else begin
        in = ni - 1;
        if (pos == ni + lat + 1) e.act_en = 1'b1;
        if (pos == ni + lat + 2) e.out_wr = 1'b1;
      end
      e.in_idx  = 8'(in);
      e.out_idx = 8'(neuron);
      e.waddr   = 8'(neuron * ni + in);
    end
    return e;
  endfunction

  task automatic drive(input bit sel, input logic s, input logic f);
    if (!sel) begin start_a = s; forget_a = f; end
    else      begin start_b = s; forget_b = f; end
  endtask

  // One pass from IDLE: drives start (with random forget, start must win),
  // optionally forget at cycle abort_at, random start while busy, and checks
  // every cycle plus the pass totals. Returns at a checked IDLE cycle.
  task automatic run_pass(input bit sel, input int abort_at, input bit hold_start, input string tag);
    int ni, nn, lat, p, total, last, wr, rd, dn, ab;
    obs_t o, e;
    bit cc;
    logic f;
    ni  = sel ? B_NI : A_NI;
    nn  = sel ? B_NN : A_NN;
    lat = sel ? B_LAT : A_LAT;
    p = ni + lat + 3; total = nn * p;
    last = (abort_at > 0) ? abort_at + 1 : total + 1;
    wr = 0; rd = 0; dn = 0; ab = 0;
    drive(sel, 1'b1, 1'($urandom_range(0, 1)));
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      o = get_obs(sel);
      e = model(ni, nn, lat, k, abort_at, cc);
      checks++;
      if (o[32:24] !== e[32:24]) begin
        errors++;
        $display("FAIL %s strobes k=%0d got %b want %b", tag, k, o[32:24], e[32:24]);
      end
      if (cc) begin
        checks++;
        if (o[23:0] !== e[23:0]) begin
          errors++;
          $display("FAIL %s indices k=%0d got in=%0d out=%0d wa=%0d want in=%0d out=%0d wa=%0d",
                   tag, k, o.in_idx, o.out_idx, o.waddr, e.in_idx, e.out_idx, e.waddr);
        end
      end
      wr += int'(o.out_wr); rd += int'(o.ag_read); dn += int'(o.done); ab += int'(o.aborted);
      if (k == last) begin
        drive(sel, hold_start, 1'($urandom_range(0, 1)));
      end else begin
        f = (k == abort_at) ? 1'b1 : 1'b0;
        drive(sel, hold_start ? 1'b1 : 1'($urandom_range(0, 1)), f);
      end
    end
    @(posedge clk); #1;
    o = get_obs(sel);
    e = model(ni, nn, lat, 0, 0, cc);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s idle_after got %h want %h", tag, o, e);
    end
    if (!hold_start) drive(sel, 1'b0, 1'b0);
    checks++;
    if (dn !== ((abort_at > 0) ? 0 : 1) || ab !== ((abort_at > 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s pulses got done=%0d aborted=%0d", tag, dn, ab);
    end
    checks++;
    if (wr !== ((abort_at > 0) ? abort_at / p : nn)) begin
      errors++;
      $display("FAIL %s out_wr_count got %0d want %0d", tag, wr, (abort_at > 0) ? abort_at / p : nn);
    end
    if (abort_at == 0) begin
      checks++;
      if (rd !== ni * nn) begin
        errors++;
        $display("FAIL %s ag_read_count got %0d want %0d", tag, rd, ni * nn);
      end
    end
  endtask

  task automatic test_reset();
    obs_t e;
    bit cc;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    #12;
    e = model(A_NI, A_NN, A_LAT, 0, 0, cc);
    checks++;
    if (get_obs(1'b0) !== e) begin
      errors++; $display("FAIL reset_a got %h want %h", get_obs(1'b0), e);
    end
    checks++;
    if (get_obs(1'b1) !== e) begin
      errors++; $display("FAIL reset_b got %h want %h", get_obs(1'b1), e);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_idle_forget();
    obs_t e;
    bit cc;
    e = model(A_NI, A_NN, A_LAT, 0, 0, cc);
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (get_obs(1'b0) !== e) begin
        errors++; $display("FAIL idle_forget cyc=%0d got %h want %h", i, get_obs(1'b0), e);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full_pass();
    run_pass(1'b0, 0, 1'b0, "full_pass_default");
    run_pass(1'b1, 0, 1'b0, "full_pass_minimal");
  endtask

  task automatic test_forget();
    run_pass(1'b0, A_NI + A_LAT + 3 + 4, 1'b0, "forget_n1_in2");
    run_pass(1'b0, 1, 1'b0, "forget_in_clear");
    run_pass(1'b0, A_NI + A_LAT + 3, 1'b0, "forget_in_write");
    run_pass(1'b1, 2, 1'b0, "forget_minimal_accum");
  endtask

  task automatic test_back_to_back();
    run_pass(1'b0, 0, 1'b1, "hold_start_1");
    run_pass(1'b0, 0, 1'b0, "hold_start_2");
  endtask

  task automatic test_random();
    bit sel;
    int total, ab;
    for (int i = 0; i < 8; i++) begin
      sel   = 1'($urandom_range(0, 1));
      total = sel ? B_NN * (B_NI + B_LAT + 3) : A_NN * (A_NI + A_LAT + 3);
      ab    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, total)) : 0;
      run_pass(sel, ab, 1'b0, "random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    obs_t e;
    bit cc;
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= A_NI + 2; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0);
    end
    e = model(A_NI, A_NN, A_LAT, A_NI + 2, 0, cc);
    checks++;
    if (get_obs(1'b0) !== e) begin
      errors++; $display("FAIL pre_reset_drain got %h want %h", get_obs(1'b0), e);
    end
    #2 reset = 1'b0;
    #1;
    e = model(A_NI, A_NN, A_LAT, 0, 0, cc);
    checks++;
    if (get_obs(1'b0) !== e) begin
      errors++; $display("FAIL async_reset got %h want %h", get_obs(1'b0), e);
    end
    @(posedge clk); #1;
    checks++;
    if (get_obs(1'b0) !== e) begin
      errors++; $display("FAIL held_reset got %h want %h", get_obs(1'b0), e);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    run_pass(1'b0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_forget();
    test_full_pass();
    test_forget();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
